// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants, types and helpers for the 32-point FFT datapath.
//   FFT_N      lanes per frame
//   FFT_W      sample width (signed two's complement)
//   FFT_LOG2N  index width for a frame
//   sample_t   one real or imaginary sample
//   bitrev()   reverses the low 'bits' bits of an index (up to 7 bits)
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_W     = 9;
    localparam int FFT_LOG2N = 5;

    typedef logic signed [FFT_W-1:0] sample_t;

    // Fixed 7-bit loop so the function stays synthesizable for any frame
    // size up to 128 lanes; bits above 'bits' come back as zero.
    function automatic logic [6:0] bitrev(input logic [6:0] k, input int unsigned bits);
        logic [6:0] r;
        r = '0;
        for (int unsigned b = 0; b < 7; b++) begin
            if (b < bits) begin
                r[b] = k[bits-1-b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_in_deser_bank.sv
// ---------------------------------------------------------------------------
// fft_in_bank
// One N-lane real/imaginary register bank of the input framer.
//   clk       clock, rising edge
//   arstb     asynchronous clear, active-low
//   rstb      synchronous clear, active-low
//   we_i      write enable
//   widx_i    lane to write
//   wr_i/wi_i real / imaginary sample to write
//   rd_r_o    packed real lanes, lane k at [W*k +: W]
//   rd_i_o    packed imaginary lanes, same packing
// ---------------------------------------------------------------------------
module fft_in_bank
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int W     = FFT_W,
    parameter int LOG2N = $clog2(N)
) (
    input  logic                clk,
    input  logic                arstb,
    input  logic                rstb,
    input  logic                we_i,
    input  logic [LOG2N-1:0]    widx_i,
    input  logic signed [W-1:0] wr_i,
    input  logic signed [W-1:0] wi_i,
    output logic [N*W-1:0]      rd_r_o,
    output logic [N*W-1:0]      rd_i_o
);

    logic signed [W-1:0] lane_r_q [N];
    logic signed [W-1:0] lane_i_q [N];

    always_ff @(posedge clk or negedge arstb) begin
        if (!arstb) begin
            for (int l = 0; l < N; l++) begin
                lane_r_q[l] <= '0;
                lane_i_q[l] <= '0;
            end
        end else if (!rstb) begin
            for (int l = 0; l < N; l++) begin
                lane_r_q[l] <= '0;
                lane_i_q[l] <= '0;
            end
        end else if (we_i) begin
            lane_r_q[widx_i] <= wr_i;
            lane_i_q[widx_i] <= wi_i;
        end
    end

    always_comb begin
        rd_r_o = '0;
        rd_i_o = '0;
        for (int l = 0; l < N; l++) begin
            rd_r_o[W*l +: W] = lane_r_q[l];
            rd_i_o[W*l +: W] = lane_i_q[l];
        end
    end

endmodule

// File: rtl/fft_in_deser.sv
// ---------------------------------------------------------------------------
// fft_in_deser
// Serial-to-parallel input framer: collects one complex sample per handshake
// into N-lane frames using two ping-pong banks and presents full frames in
// parallel. Frame boundaries are checked against in_last.
//   clk, arstb (async, active-low), rstb (sync, active-low)
//   in_valid/in_ready/in_r/in_i/in_last   sample input stream
//   out_valid/out_ready/out_r/out_i        frame output, lane k at [W*k +: W]
//   frame_err                              one-cycle pulse on a framing error
// Build option: define FFT_BITREV_EN to write sample k into lane
// bitrev(k), giving bit-reversed output frames. Default is natural order.
// ---------------------------------------------------------------------------
module fft_in_deser
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic                clk,
    input  logic                arstb,
    input  logic                rstb,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_r,
    input  logic signed [W-1:0] in_i,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*W-1:0]      out_r,
    output logic [N*W-1:0]      out_i,
    output logic                frame_err
);

    localparam int               LOG2N   = $clog2(N);
    localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N-1);

    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic [1:0]       full_q, full_d;
    logic             frame_err_q, frame_err_d;

    logic             accept;
    logic             consume;
    logic [LOG2N-1:0] wlane;
    logic [N*W-1:0]   bank_r [2];
    logic [N*W-1:0]   bank_i [2];

    assign in_ready  = ~full_q[wsel_q];
    assign out_valid = full_q[rsel_q];
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign frame_err = frame_err_q;

`ifdef FFT_BITREV_EN
    assign wlane = LOG2N'(bitrev(7'(idx_q), LOG2N));
`else
    assign wlane = idx_q;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_in_bank #(.N(N), .W(W), .LOG2N(LOG2N)) u_bank (
            .clk    (clk),
            .arstb  (arstb),
            .rstb   (rstb),
            .we_i   (accept && (wsel_q == 1'(b))),
            .widx_i (wlane),
            .wr_i   (in_r),
            .wi_i   (in_i),
            .rd_r_o (bank_r[b]),
            .rd_i_o (bank_i[b])
        );
    end

    assign out_r = rsel_q ? bank_r[1] : bank_r[0];
    assign out_i = rsel_q ? bank_i[1] : bank_i[0];

    // Commit and consume never touch the same bank in one cycle, because a
    // full bank blocks writes, so both updates can be applied independently.
    always_comb begin
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        idx_d       = idx_q;
        full_d      = full_q;
        frame_err_d = 1'b0;
        if (accept) begin
            if (idx_q == IDX_MAX) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                idx_d          = '0;
                frame_err_d    = ~in_last;
            end else if (in_last) begin
                // Early last: drop the partial frame; stale lanes get
                // overwritten by the next frame before it is ever shown.
                idx_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (consume) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
        end
    end

    always_ff @(posedge clk or negedge arstb) begin
        if (!arstb) begin
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            idx_q       <= '0;
            full_q      <= '0;
            frame_err_q <= 1'b0;
        end else if (!rstb) begin
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            idx_q       <= '0;
            full_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            idx_q       <= idx_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
